// File: rtl/dijkstra_path_streamer_if.sv
// Hop stream bundle between the path streamer (master) and the route/display consumer (slave).
// Valid/ready handshake: a hop transfers on any cycle where hop_valid and hop_ready are both high.
interface dijkstra_path_streamer_if #(
    parameter int NODE_W   = 5,
    parameter int MAX_HOPS = 10
);
    localparam int IDX_W = (MAX_HOPS > 1) ? $clog2(MAX_HOPS) : 1;

    logic [NODE_W-1:0] hop_node;
    logic              hop_valid;
    logic              hop_ready;
    logic              hop_last;
    logic [IDX_W-1:0]  hop_index;

    modport master (
        output hop_node,
        output hop_valid,
        output hop_last,
        output hop_index,
        input  hop_ready
    );

    modport slave (
        input  hop_node,
        input  hop_valid,
        input  hop_last,
        input  hop_index,
        output hop_ready
    );
endinterface

// File: rtl/dijkstra_path_streamer.sv
// Shadows the Dijkstra final_path on the rising edge of path_done and streams it hop by hop.
// Define DIJKSTRA_LOOP_DETECT_EN to build the seen-node bitmap that drives loop_err.
module dijkstra_path_streamer #(
    parameter int NODE_W   = 5,
    parameter int MAX_HOPS = 10,
    parameter int SENTINEL = 31
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         path_done,
    input  logic [MAX_HOPS*NODE_W-1:0]   final_path,
    input  logic [NODE_W-1:0]            e_node,
    dijkstra_path_streamer_if.master     hop,
    output logic                         busy,
    output logic                         stream_done,
    output logic                         path_err,
    output logic                         loop_err
);
    localparam int                IDX_W    = (MAX_HOPS > 1) ? $clog2(MAX_HOPS) : 1;
    localparam logic [NODE_W-1:0] SENT     = NODE_W'(SENTINEL);
    localparam logic [IDX_W-1:0]  IDX_ZERO = '0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_FIN    = 2'd3;

    logic [1:0]                 state_reg;
    logic [1:0]                 state_next;
    logic                       done_prev_reg;
    logic [MAX_HOPS*NODE_W-1:0] path_reg;
    logic [NODE_W-1:0]          end_node_reg;
    logic [IDX_W-1:0]           idx_reg;
    logic [IDX_W-1:0]           idx_next;
    logic                       path_err_reg;
    logic                       path_err_next;

    logic [NODE_W-1:0]          slot [MAX_HOPS];
    logic [MAX_HOPS-1:0]        tail_empty;

    logic                       capture;
    logic                       streaming;
    logic                       accept;
    logic [NODE_W-1:0]          cur_node;
    logic                       cur_is_end;
    logic                       cur_last;

    // tail_empty[i]: no further hop can follow slot i (next slot unused, or i is the final slot).
    generate
        for (genvar gi = 0; gi < MAX_HOPS; gi++) begin : g_slot
            assign slot[gi] = path_reg[gi*NODE_W +: NODE_W];
            if (gi == MAX_HOPS - 1) begin : g_tail_last
                assign tail_empty[gi] = 1'b1;
            end else begin : g_tail_mid
                assign tail_empty[gi] = (path_reg[(gi+1)*NODE_W +: NODE_W] == SENT);
            end
        end
    endgenerate

    assign capture    = (state_reg == ST_IDLE) && path_done && !done_prev_reg;
    assign streaming  = (state_reg == ST_STREAM);
    assign accept     = streaming && hop.hop_ready;
    assign cur_node   = slot[idx_reg];
    assign cur_is_end = (cur_node == end_node_reg);
    assign cur_last   = cur_is_end || tail_empty[idx_reg];

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        path_err_next = path_err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (capture) begin
                    state_next    = ST_LOAD;
                    idx_next      = IDX_ZERO;
                    path_err_next = 1'b0;
                end
            end
            ST_LOAD: begin
                idx_next = IDX_ZERO;
                if (slot[0] == SENT) begin
                    state_next    = ST_FIN;
                    path_err_next = 1'b1;
                end else begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    if (cur_last) begin
                        state_next = ST_FIN;
                        if (!cur_is_end) begin
                            path_err_next = 1'b1;
                        end
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The edge detector follows path_done in every state so a held level never retriggers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            done_prev_reg <= 1'b0;
            path_reg      <= '0;
            end_node_reg  <= '0;
            idx_reg       <= '0;
            path_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            done_prev_reg <= path_done;
            idx_reg       <= idx_next;
            path_err_reg  <= path_err_next;
            if (capture) begin
                path_reg     <= final_path;
                end_node_reg <= e_node;
            end
        end
    end

    assign hop.hop_valid = streaming;
    assign hop.hop_node  = streaming ? cur_node : '0;
    assign hop.hop_last  = streaming && cur_last;
    assign hop.hop_index = streaming ? idx_reg : '0;

    assign busy        = (state_reg == ST_LOAD) || (state_reg == ST_STREAM);
    assign stream_done = (state_reg == ST_FIN);
    assign path_err    = path_err_reg;

`ifdef DIJKSTRA_LOOP_DETECT_EN
    logic [(1<<NODE_W)-1:0] seen_reg;
    logic                   loop_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            seen_reg     <= '0;
            loop_err_reg <= 1'b0;
        end else if (capture) begin
            seen_reg     <= '0;
            loop_err_reg <= 1'b0;
        end else if (accept) begin
            seen_reg[cur_node] <= 1'b1;
            if (seen_reg[cur_node]) begin
                loop_err_reg <= 1'b1;
            end
        end
    end

    assign loop_err = loop_err_reg;
`else
    assign loop_err = 1'b0;
`endif

endmodule

// File: tb/tb_dijkstra_path_streamer.sv
// Scoreboard bench for dijkstra_path_streamer: directed paths push expected hops/completions,
// a negedge monitor pops and compares whenever a hop is accepted or stream_done pulses.
module tb_dijkstra_path_streamer;
    localparam int NODE_W   = 5;
    localparam int MAX_HOPS = 10;

`ifdef DIJKSTRA_LOOP_DETECT_EN
    localparam bit LOOP_ON = 1'b1;
`else
    localparam bit LOOP_ON = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       path_done = 1'b0;
    logic [MAX_HOPS*NODE_W-1:0] final_path = '0;
    logic [NODE_W-1:0]          e_node = '0;
    logic                       busy;
    logic                       stream_done;
    logic                       path_err;
    logic                       loop_err;

    dijkstra_path_streamer_if #(.NODE_W(NODE_W), .MAX_HOPS(MAX_HOPS)) hop_bus ();

    dijkstra_path_streamer #(.NODE_W(NODE_W), .MAX_HOPS(MAX_HOPS), .SENTINEL(31)) dut (
        .clk         (clk),
        .reset       (reset),
        .path_done   (path_done),
        .final_path  (final_path),
        .e_node      (e_node),
        .hop         (hop_bus),
        .busy        (busy),
        .stream_done (stream_done),
        .path_err    (path_err),
        .loop_err    (loop_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] node;
        logic       last;
        logic [3:0] idx;
    } hop_t;

    typedef struct packed {
        logic perr;
        logic lerr;
    } done_t;

    hop_t       hop_q[$];
    done_t      done_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [4:0] slots [MAX_HOPS];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_hop(input int node, input bit last, input int idx);
        hop_t h;
        h.node = 5'(node);
        h.last = last;
        h.idx  = 4'(idx);
        hop_q.push_back(h);
    endtask

    task automatic push_done(input bit perr, input bit lerr);
        done_t d;
        d.perr = perr;
        d.lerr = lerr;
        done_q.push_back(d);
    endtask

    task automatic clear_slots();
        for (int i = 0; i < MAX_HOPS; i++) slots[i] = 5'd31;
    endtask

    task automatic drive_path(input int end_node);
        for (int i = 0; i < MAX_HOPS; i++) final_path[i*NODE_W +: NODE_W] = slots[i];
        e_node = 5'(end_node);
    endtask

    // Raises path_done, scrambles the live inputs after capture, and waits for completion.
    task automatic run_path(input string tag, input int end_node, input bit toggle,
                            input bit empty, input bit perr);
        int cnt;
        drive_path(end_node);
        hop_bus.hop_ready = 1'b1;
        path_done = 1'b1;
        @(posedge clk); #1;
        final_path = '1;
        e_node     = 5'd0;
        check({tag, "_load_busy"}, int'(busy), 1);
        @(posedge clk); #1;
        check({tag, "_first_valid"}, int'(hop_bus.hop_valid), empty ? 0 : 1);
        check({tag, "_first_done"}, int'(stream_done), empty ? 1 : 0);
        cnt = 0;
        while (!stream_done && cnt < 200) begin
            if (toggle) hop_bus.hop_ready = ~hop_bus.hop_ready;
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_done_seen"}, int'(stream_done), 1);
        hop_bus.hop_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_done_pulse_width"}, int'(stream_done), 0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_no_retrigger"}, int'(busy), 0);
        check({tag, "_path_err_sticky"}, int'(path_err), int'(perr));
        check({tag, "_hops_left"}, hop_q.size(), 0);
        check({tag, "_dones_left"}, done_q.size(), 0);
        path_done = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: compares accepted hops and completions against the scoreboard queues.
    initial begin
        hop_t  held;
        hop_t  exp_h;
        done_t exp_d;
        bit    pend;
        pend = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("hold_valid", int'(hop_bus.hop_valid), 1);
                    check("hold_node", int'(hop_bus.hop_node), int'(held.node));
                    check("hold_last", int'(hop_bus.hop_last), int'(held.last));
                    check("hold_index", int'(hop_bus.hop_index), int'(held.idx));
                end
                check("valid_done_exclusive", int'(hop_bus.hop_valid & stream_done), 0);
                if (hop_bus.hop_valid && hop_bus.hop_ready) begin
                    checks++;
                    if (hop_q.size() == 0) begin
                        failures++;
                        $display("FAIL hop_unexpected actual=node%0d expected=no_hop",
                                 hop_bus.hop_node);
                    end else begin
                        exp_h = hop_q.pop_front();
                        if (hop_bus.hop_node !== exp_h.node || hop_bus.hop_last !== exp_h.last ||
                            hop_bus.hop_index !== exp_h.idx) begin
                            failures++;
                            $display("FAIL hop actual=node%0d/last%0d/idx%0d expected=node%0d/last%0d/idx%0d",
                                     hop_bus.hop_node, hop_bus.hop_last, hop_bus.hop_index,
                                     exp_h.node, exp_h.last, exp_h.idx);
                        end else begin
                            $display("hop node=%0d last=%0d idx=%0d ok",
                                     hop_bus.hop_node, hop_bus.hop_last, hop_bus.hop_index);
                        end
                    end
                end
                if (stream_done) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        failures++;
                        $display("FAIL done_unexpected actual=stream_done expected=none");
                    end else begin
                        exp_d = done_q.pop_front();
                        if (path_err !== exp_d.perr || loop_err !== exp_d.lerr) begin
                            failures++;
                            $display("FAIL done_flags actual=perr%0d/lerr%0d expected=perr%0d/lerr%0d",
                                     path_err, loop_err, exp_d.perr, exp_d.lerr);
                        end else begin
                            $display("done path_err=%0d loop_err=%0d ok", path_err, loop_err);
                        end
                    end
                end
                pend      = hop_bus.hop_valid && !hop_bus.hop_ready;
                held.node = hop_bus.hop_node;
                held.last = hop_bus.hop_last;
                held.idx  = hop_bus.hop_index;
            end
        end
    end

    initial begin
        hop_bus.hop_ready = 1'b0;
        clear_slots();
        repeat (3) @(posedge clk);
        #1;
        check("rst_hop_valid", int'(hop_bus.hop_valid), 0);
        check("rst_hop_node", int'(hop_bus.hop_node), 0);
        check("rst_hop_last", int'(hop_bus.hop_last), 0);
        check("rst_hop_index", int'(hop_bus.hop_index), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_stream_done", int'(stream_done), 0);
        check("rst_path_err", int'(path_err), 0);
        check("rst_loop_err", int'(loop_err), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // T1: 0,1,5,11 back to back, ready held high
        clear_slots();
        slots[0] = 5'd0; slots[1] = 5'd1; slots[2] = 5'd5; slots[3] = 5'd11;
        push_hop(0, 0, 0); push_hop(1, 0, 1); push_hop(5, 0, 2); push_hop(11, 1, 3);
        push_done(1'b0, 1'b0);
        run_path("t1", 11, 1'b0, 1'b0, 1'b0);

        // T2: same path, ready toggling
        push_hop(0, 0, 0); push_hop(1, 0, 1); push_hop(5, 0, 2); push_hop(11, 1, 3);
        push_done(1'b0, 1'b0);
        run_path("t2", 11, 1'b1, 1'b0, 1'b0);

        // T3: empty path
        clear_slots();
        push_done(1'b1, 1'b0);
        run_path("t3", 11, 1'b0, 1'b1, 1'b1);

        // T4: all ten slots used, end node never appears
        for (int i = 0; i < MAX_HOPS; i++) slots[i] = 5'(2 * i);
        for (int i = 0; i < MAX_HOPS; i++) push_hop(2 * i, (i == MAX_HOPS - 1), i);
        push_done(1'b1, 1'b0);
        run_path("t4", 17, 1'b0, 1'b0, 1'b1);

        // T5: reset while hop 2 is presented, then restart with end node 5
        clear_slots();
        slots[0] = 5'd0; slots[1] = 5'd1; slots[2] = 5'd5; slots[3] = 5'd11;
        drive_path(11);
        push_hop(0, 0, 0); push_hop(1, 0, 1);
        hop_bus.hop_ready = 1'b1;
        path_done = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t5_pre_reset_index", int'(hop_bus.hop_index), 2);
        check("t5_pre_reset_node", int'(hop_bus.hop_node), 5);
        hop_bus.hop_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_reset_valid", int'(hop_bus.hop_valid), 0);
        check("t5_reset_busy", int'(busy), 0);
        check("t5_reset_no_done", int'(stream_done), 0);
        path_done = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("t5_aborted_hops_left", hop_q.size(), 0);
        push_hop(0, 0, 0); push_hop(1, 0, 1); push_hop(5, 1, 2);
        push_done(1'b0, 1'b0);
        run_path("t5", 5, 1'b0, 1'b0, 1'b0);

        // T6: repeated node 0
        clear_slots();
        slots[0] = 5'd0; slots[1] = 5'd3; slots[2] = 5'd0; slots[3] = 5'd7;
        push_hop(0, 0, 0); push_hop(3, 0, 1); push_hop(0, 0, 2); push_hop(7, 1, 3);
        push_done(1'b0, LOOP_ON);
        run_path("t6", 7, 1'b0, 1'b0, 1'b0);
        check("t6_loop_err_sticky", int'(loop_err), int'(LOOP_ON));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
